// File: rtl/opc5_serial_boot.sv
// -----------------------------------------------------------------------------
// opc5_serial_boot
//
// Serial boot loader sitting between the UART receive path and the OPC5
// CPU/RAM pair. While the CPU is held in reset it receives a framed program
// image one byte at a time:
//
//   SYNC_BYTE, LEN_H, LEN_L, ADR_H, ADR_L, {DAT_H, DAT_L} x N, CSUM
//
// Each data word is written to RAM at the load address (incrementing, wrapping
// at 16 bits). The 8-bit sum of every byte after SYNC, CSUM included, must be
// zero for the frame to be accepted. On success the CPU is released and the
// loader parks in DONE until reset.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-high reset
//   rx_data      received byte, qualified by rx_valid
//   rx_valid     one-cycle strobe per received byte
//   mem_addr     RAM write address
//   mem_dout     RAM write data
//   mem_we       one-cycle RAM write strobe
//   cpu_reset_b  active-low CPU reset, released after a good frame
//   boot_done    high once a frame has checksummed correctly
//   boot_error   sticky error flag: checksum failure or inter-byte timeout
// -----------------------------------------------------------------------------
module opc5_serial_boot #(
    parameter int          CLKSPEED       = 32000000,
    parameter int          TIMEOUT_CYCLES = CLKSPEED / 100,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_dout,
    output logic        mem_we,
    output logic        cpu_reset_b,
    output logic        boot_done,
    output logic        boot_error
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_SYNC,
        ST_LEN_H,
        ST_LEN_L,
        ST_ADR_H,
        ST_ADR_L,
        ST_DAT_H,
        ST_DAT_L,
        ST_CSUM,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   len_q, len_d;          // words still to be received
    logic [15:0]   addr_q, addr_d;        // address of the next word
    logic [7:0]    hi_q, hi_d;            // high byte of the word in flight
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic [15:0]   mem_dout_q, mem_dout_d;
    logic          mem_we_q, mem_we_d;
    logic          cpu_reset_b_q, cpu_reset_b_d;
    logic          boot_done_q, boot_done_d;
    logic          boot_error_q, boot_error_d;

    logic [7:0]    csum_sum;
    logic          in_frame;

    assign csum_sum = csum_q + rx_data;
    assign in_frame = (state_q != ST_SYNC) && (state_q != ST_DONE);

    always_comb begin
        // NOTE: every *_d gets a default before any branch; a path that left
        // one unassigned would make synthesis infer a latch.
        state_d       = state_q;
        len_d         = len_q;
        addr_d        = addr_q;
        hi_d          = hi_q;
        csum_d        = csum_q;
        tmo_d         = tmo_q;
        mem_addr_d    = mem_addr_q;
        mem_dout_d    = mem_dout_q;
        mem_we_d      = 1'b0;
        cpu_reset_b_d = cpu_reset_b_q;
        boot_done_d   = boot_done_q;
        boot_error_d  = boot_error_q;

        // Every byte after SYNC contributes to the checksum, CSUM included.
        if (in_frame && rx_valid) begin
            csum_d = csum_sum;
        end

        unique case (state_q)
            ST_SYNC: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    csum_d       = 8'h00;
                    boot_error_d = 1'b0;
                    state_d      = ST_LEN_H;
                end
            end
            ST_LEN_H: if (rx_valid) begin
                len_d[15:8] = rx_data;
                state_d     = ST_LEN_L;
            end
            ST_LEN_L: if (rx_valid) begin
                len_d[7:0] = rx_data;
                state_d    = ST_ADR_H;
            end
            ST_ADR_H: if (rx_valid) begin
                addr_d[15:8] = rx_data;
                state_d      = ST_ADR_L;
            end
            ST_ADR_L: if (rx_valid) begin
                addr_d[7:0] = rx_data;
                state_d     = (len_q == 16'h0000) ? ST_CSUM : ST_DAT_H;
            end
            ST_DAT_H: if (rx_valid) begin
                hi_d    = rx_data;
                state_d = ST_DAT_L;
            end
            ST_DAT_L: if (rx_valid) begin
                // The write is registered and issued on the following cycle,
                // so the next byte can be accepted immediately.
                mem_we_d   = 1'b1;
                mem_dout_d = {hi_q, rx_data};
                mem_addr_d = addr_q;
                addr_d     = addr_q + 16'h0001;
                len_d      = len_q - 16'h0001;
                state_d    = (len_q == 16'h0001) ? ST_CSUM : ST_DAT_H;
            end
            ST_CSUM: if (rx_valid) begin
                if (csum_sum == 8'h00) begin
                    state_d       = ST_DONE;
                    boot_done_d   = 1'b1;
                    cpu_reset_b_d = 1'b1;
                end else begin
                    boot_error_d = 1'b1;
                    state_d      = ST_SYNC;
                end
            end
            ST_DONE: begin
            end
            default: state_d = ST_SYNC;
        endcase

        // Inter-byte timeout. A byte on the expiry cycle wins, because the
        // expiry branch is only reached when rx_valid is low.
        if (!in_frame || rx_valid) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            tmo_d        = '0;
            boot_error_d = 1'b1;
            state_d      = ST_SYNC;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples its _d value from before this edge.
        if (reset) begin
            state_q       <= ST_SYNC;
            len_q         <= 16'h0000;
            addr_q        <= 16'h0000;
            hi_q          <= 8'h00;
            csum_q        <= 8'h00;
            tmo_q         <= '0;
            mem_addr_q    <= 16'h0000;
            mem_dout_q    <= 16'h0000;
            mem_we_q      <= 1'b0;
            cpu_reset_b_q <= 1'b0;
            boot_done_q   <= 1'b0;
            boot_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            addr_q        <= addr_d;
            hi_q          <= hi_d;
            csum_q        <= csum_d;
            tmo_q         <= tmo_d;
            mem_addr_q    <= mem_addr_d;
            mem_dout_q    <= mem_dout_d;
            mem_we_q      <= mem_we_d;
            cpu_reset_b_q <= cpu_reset_b_d;
            boot_done_q   <= boot_done_d;
            boot_error_q  <= boot_error_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_dout    = mem_dout_q;
    assign mem_we      = mem_we_q;
    assign cpu_reset_b = cpu_reset_b_q;
    assign boot_done   = boot_done_q;
    assign boot_error  = boot_error_q;

endmodule
